// File: rtl/seg7_pkg.sv
// Shared types and the active-low 0-F glyph table for the seg7 scan display.
package seg7_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, 0 = segment lit

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 7-segment scanner with blanking and blinking.
// Define SEG7_LZ_SUPPRESS_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    apaga,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output seg_t                    seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_q, blk_d;
  logic                    blink_off_q, blink_off_d;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       tick;
  logic       frame_done;
  logic [3:0] nib [NUM_DIGITS];
  logic [3:0] cur_nib;
  seg_t       cur_glyph;
  logic       lz_off;
  logic       digit_off;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = shadow_q[4*gi +: 4];
    end
  endgenerate

  assign tick       = (pre_q == PRE_LAST);
  assign frame_done = tick && (idx_q == IDX_LAST);
  assign cur_nib    = nib[idx_q];

  seg7_glyph u_glyph (
    .nibble_i (cur_nib),
    .seg_o    (cur_glyph)
  );

`ifdef SEG7_LZ_SUPPRESS_EN
  // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_acc;

  always_comb begin
    upper_zero = '0;
    zero_acc   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (nib[i] == 4'h0);
      upper_zero[i] = zero_acc;
    end
  end

  assign lz_off = (idx_q != '0) && upper_zero[idx_q];
`else
  assign lz_off = 1'b0;
`endif

  assign digit_off = apaga
                   | blank_mask[idx_q]
                   | (blink_mask[idx_q] & blink_off_q)
                   | lz_off;

  always_comb begin
    shadow_d    = load ? value : shadow_q;
    pre_d       = tick ? '0 : pre_q + 1'b1;
    idx_d       = idx_q;
    blk_d       = blk_q;
    blink_off_d = blink_off_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (frame_done) begin
      if (blk_q == BLK_LAST) begin
        blk_d       = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    // Outputs come from this cycle's state, so they trail it by one edge
    an_d  = digit_off ? '1 : ~(AN_ONE << idx_q);
    seg_d = digit_off ? SEG_OFF : cur_glyph;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      pre_q       <= '0;
      idx_q       <= '0;
      blk_q       <= '0;
      blink_off_q <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
    end else begin
      shadow_q    <= shadow_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      blk_q       <= blk_d;
      blink_off_q <= blink_off_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (4 digits, scan 4, blink 2).
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        apaga = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  an;

  seg7_scan_display #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .apaga      (apaga),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         phase;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int phase = 0;
  logic [15:0] sh = '0;

  // Hand-copied glyph patterns, index = nibble
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Expected outputs at edge number cyc counted from reset release
  function automatic exp_t expect_now();
    exp_t e;
    int   d;
    logic boff;
    logic off;
    d    = (cyc / SD) % ND;
    boff = ((cyc / (SD * ND * BD)) % 2) == 1;
    off  = apaga | blank_mask[d] | (blink_mask[d] & boff);
`ifdef SEG7_LZ_SUPPRESS_EN
    if (d >= 1 && (sh >> (4 * d)) == 16'h0) off = 1'b1;
`endif
    e.an    = off ? 4'hF : ~(4'b0001 << d);
    e.seg   = off ? 7'h7F : glyph_tab[sh[4*d +: 4]];
    e.phase = phase;
    e.cyc   = cyc;
    return e;
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic ap,
                      input logic [3:0] bm, input logic [3:0] km);
    load       = ld;
    value      = v;
    apaga      = ap;
    blank_mask = bm;
    blink_mask = km;
    sb.push_back(expect_now());
    if (ld) sh = v;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic ap, input logic [3:0] bm, input logic [3:0] km);
    for (int i = 0; i < n; i++) step(1'b0, 16'hDEAD, ap, bm, km);
  endtask

  task automatic check_reset(input string tag);
    total++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      bad++;
      $display("FAIL reset_%s an=%b seg=%b expected an=1111 seg=1111111", tag, an, seg);
    end else begin
      $display("ok reset_%s an=%b seg=%b", tag, an, seg);
    end
  endtask

  // Monitor: one scoreboard entry per edge after release
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (an !== e.an || seg !== e.seg) begin
          bad++;
          $display("FAIL scan phase=%0d cyc=%0d an=%b seg=%b expected an=%b seg=%b",
                   e.phase, e.cyc, an, seg, e.an, e.seg);
        end else begin
          $display("ok scan phase=%0d cyc=%0d an=%b seg=%b", e.phase, e.cyc, an, seg);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset("initial");
    rst_n = 1'b1;
    cyc   = 0;
    sh    = '0;

    phase = 1;  // scan order with shadow 0
    run(23, 1'b0, 4'h0, 4'h0);

    phase = 2;  // load on a tick edge, then decode every digit
    step(1'b1, 16'h12AF, 1'b0, 4'h0, 4'h0);
    run(16, 1'b0, 4'h0, 4'h0);

    phase = 3;  // global blank, scan keeps running
    run(3, 1'b1, 4'h0, 4'h0);
    run(8, 1'b0, 4'h0, 4'h0);

    phase = 4;  // blink digit 0 across on/off phases
    step(1'b1, 16'h1111, 1'b0, 4'h0, 4'h1);
    run(80, 1'b0, 4'h0, 4'h1);

    phase = 5;  // per-digit blank
    run(8, 1'b0, 4'h4, 4'h0);

    phase = 6;  // leading zeros
    step(1'b1, 16'h0050, 1'b0, 4'h0, 4'h0);
    run(15, 1'b0, 4'h0, 4'h0);

    phase = 7;  // lit digit 0 before mid-frame reset
    step(1'b1, 16'h8888, 1'b0, 4'h0, 4'h0);
    run(4, 1'b0, 4'h0, 4'h0);

    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    @(posedge clk);
    #1;
    check_reset("held");
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    sh    = '0;
    phase = 8;  // restart from digit 0 with cleared shadow
    run(6, 1'b0, 4'h0, 4'h0);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Time-multiplexed driver for a bank of common-anode 7-segment digits sharing one active-low segment bus. Latches a packed hex value, scans one digit per scan tick, and decodes each nibble to its 0–F glyph. Supports global blanking, per-digit blanking and per-digit blinking. Sits between datapath/status registers and the board display pins, replacing one decoder instance per digit.

## Interface
- `NUM_DIGITS`, 4: number of digits; legal range 1..8.
- `SCAN_DIV`, 50000: clock cycles per scan tick, i.e. per digit slot; must be ≥1.
- `BLINK_DIV`, 64: completed frames per blink phase toggle; must be ≥1.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 4*NUM_DIGITS: packed nibbles; digit i is `value[4i+3:4i]`, and digit 0 is the rightmost.
- `load` in 1: capture `value` into the shadow register on this edge.
- `apaga` in 1: global blank; 1 turns the whole display off.
- `blank_mask` in NUM_DIGITS: bit i=1 keeps digit i permanently off.
- `blink_mask` in NUM_DIGITS: bit i=1 turns digit i off during the blink-off phase.
- `seg` out 7: active-low segments `{g,f,e,d,c,b,a}`, registered.
- `an` out NUM_DIGITS: active-low digit enables, one-hot-low, registered.

## Operation
- **Shadow register:** captures `value` on any edge where `load`=1 and holds it otherwise. `value` is ignored while `load`=0.
- **Prescaler:** counts 0..SCAN_DIV-1 and wraps. A scan tick is the cycle on which the count equals SCAN_DIV-1.
- **Digit index:** advances by 1 on each tick, wrapping NUM_DIGITS-1 → 0.
- **Frame and blink counter:** a frame completes when the index wraps to 0. The blink counter counts frames 0..BLINK_DIV-1. `blink_off` toggles on the frame that wraps the counter.
- **Digit off condition:** the selected digit `d` is off if any of these is true:
  - `apaga`=1
  - `blank_mask[d]`=1
  - `blink_mask[d]`=1 and `blink_off`=1
  - it is suppressed by leading-zero suppression (see Configuration)
- **Off digit outputs:** `an`='1 and `seg`=7'h7F.
- **Lit digit outputs:** `an`=~(1<<d) and `seg`=glyph(shadow nibble d).
- **Glyph table:** active-low; values are `seg` for each nibble.
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Simultaneous `load` and tick:** both take effect on the same edge.
- **Mask and `apaga` inputs:** sampled every cycle; they are not latched.

## Timing
- **Reset values:** shadow=0, prescaler=0, index=0, blink counter=0, `blink_off`=0, `seg`=7'h7F, `an`='1.
- **Output register:** `seg` and `an` are computed from the current-cycle state and inputs and registered. Outputs therefore lag state by one cycle.
- **Load latency:** a `load` at edge N is visible on `seg` at edge N+1 if that digit is selected.
- **First output after reset release:** at the first edge, digit 0 is shown with glyph 0.
- **Digit hold time:** each digit is held for exactly SCAN_DIV cycles. A frame lasts NUM_DIGITS*SCAN_DIV cycles.
- **Blanking latency:** `apaga` and mask changes reach the outputs at the next edge.
- **Reset mid-scan:** all state and outputs go to their reset values immediately, with no clock needed. The scan restarts at digit 0.
- **SCAN_DIV=1:** the index advances every cycle.
- **NUM_DIGITS=1:** the index is constant 0 and every tick completes a frame.

## Configuration
- **Macro:** `SEG7_LZ_SUPPRESS_EN` enables leading-zero suppression.
- **Defined:** digit i (i≥1) is suppressed when shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- **Not defined:** no suppression logic exists and every nibble is displayed.

## Structure
- **Package `seg7_pkg`:**
  - `GLYPH` constant array [16] of 7-bit active-low patterns
  - `SEG_OFF`=7'h7F
  - `seg_t` typedef (logic [6:0])
- **Sub-module `seg7_glyph`:** one instance, combinational nibble → `seg_t` lookup on the muxed nibble.
- **Top level:** prescaler, index, blink counter, shadow register and output register all live in the top.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
1. **Reset:** assert `rst_n`=0 mid-frame → `seg`=7'h7F and `an`=4'hF immediately, without a clock edge. After release, the first edge gives `an`=4'b1110 and `seg`=1000000.
2. **Scan order:** run 16 cycles → `an` sequence is 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
3. **Decode:** `load` with `value`=16'h12AF → `seg` per digit:
   - digit 0: 0001110
   - digit 1: 0001000
   - digit 2: 0100100
   - digit 3: 1111001
4. **Global blank:** `apaga`=1 for 3 cycles → `seg`=7'h7F and `an`=4'hF from the next edge. The display resumes on the correct scan slot, since the index kept running.
5. **Blink:** `blink_mask`=4'b0001 and `value`=16'h1111 → digit 0 is lit for 2 frames (32 cycles), then `an` stays high for 2 frames. Digits 1–3 are unaffected.
6. **Leading-zero suppression** with `value`=16'h0050:
   - With `SEG7_LZ_SUPPRESS_EN`: digits 2 and 3 stay off, digit 1 shows 5, digit 0 shows 0.
   - Without it: all four digits are lit.
